// File: rtl/ioctl_ascii_loader.sv
// ioctl_ascii_loader: buffers an HPS file download in a small FIFO and
// replays it as 8N2 serial into an ACIA receive pin.
`timescale 1ns/1ps
module ioctl_ascii_loader #(
  parameter int CLK_HZ = 48000000,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   enable,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [7:0]             ioctl_data,
  output logic                   ioctl_wait,
  input  logic [1:0]             baud_sel,
  input  logic [1:0]             eol_mode,
  output logic                   txd,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLK_HZ / 300 + 1);

  localparam logic [CW-1:0] P300 = CW'(CLK_HZ / 300);
  localparam logic [CW-1:0] P1K2 = CW'(CLK_HZ / 1200);
  localparam logic [CW-1:0] P9K6 = CW'(CLK_HZ / 9600);
  localparam logic [CW-1:0] P115 = CW'(CLK_HZ / 115200);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] HIGH = (AW+1)'(DEPTH - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP1,
    S_STOP2
  } state_e;

  function automatic logic [CW-1:0] period(input logic [1:0] s);
    logic [CW-1:0] p;
    unique case (s)
      2'd0: p = P300;
      2'd1: p = P1K2;
      2'd2: p = P9K6;
      2'd3: p = P115;
    endcase
    return p;
  endfunction

  logic [1:0]    sync_q;
  logic          run;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] per_q, per_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bit_q, bit_d;
  logic          txd_q, txd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   lvl_q, lvl_d;
  logic          wait_q, wait_d;
  logic          ovf_q, ovf_d;
  logic          dl_q, dl_d;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    wdata;
  logic          keep, req, push, load, fire;

  // Release is synchronised; assertion stays asynchronous.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign run = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    txd_d   = txd_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    lvl_d   = lvl_q;
    ovf_d   = ovf_q;
    dl_d    = ioctl_download;
    wait_d  = (lvl_q >= HIGH);
    load    = 1'b0;
    fire    = (cnt_q == per_q - CW'(1));

    keep  = !((eol_mode == 2'd1 && ioctl_data == 8'h0A) ||
              (eol_mode == 2'd3 && ioctl_data == 8'h0D));
    wdata = (eol_mode == 2'd2 && ioctl_data == 8'h0A) ?
            8'h0D : ioctl_data;
    req   = run && enable && ioctl_download &&
            ioctl_wr && keep;
    push  = req && (lvl_q != FULL);

    if (ioctl_download && !dl_q) ovf_d = 1'b0;
    if (req && lvl_q == FULL) ovf_d = 1'b1;

    unique case (state_q)
      S_IDLE: load = (lvl_q != '0);
      S_START: begin
        if (fire) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          txd_d   = sh_q[0];
        end
      end
      S_DATA: begin
        if (fire) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP1;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            txd_d = sh_q[1];
          end
        end
      end
      S_STOP1: if (fire) state_d = S_STOP2;
      S_STOP2: begin
        if (fire) begin
          state_d = S_IDLE;
          load    = (lvl_q != '0);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE) cnt_d = fire ? '0 : cnt_q + CW'(1);

    // Reload straight into START so queued frames run gap-free.
    if (load) begin
      state_d = S_START;
      txd_d   = 1'b0;
      cnt_d   = '0;
      per_d   = period(baud_sel);
      sh_d    = mem[rd_q];
      rd_d    = rd_q + AW'(1);
    end

    if (push) wr_d = wr_q + AW'(1);
    if (push && !load) lvl_d = lvl_q + (AW+1)'(1);
    else if (load && !push) lvl_d = lvl_q - (AW+1)'(1);

    if (!run || !enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      bit_d   = 3'd0;
      txd_d   = 1'b1;
      wr_d    = '0;
      rd_d    = '0;
      lvl_d   = '0;
      wait_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      wait_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      wait_q  <= wait_d;
      ovf_q   <= ovf_d;
      dl_q    <= dl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= wdata;
  end

  assign txd        = txd_q;
  assign ioctl_wait = wait_q;
  assign overflow   = ovf_q;
  assign level      = lvl_q;
  assign busy       = (lvl_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_ioctl_ascii_loader.sv
// tb_ioctl_ascii_loader: directed + random stimulus, UART-decoding
// monitor and queue model of the expected byte stream.
`timescale 1ns/1ps
module tb_ioctl_ascii_loader;

  localparam int CLK_HZ = 1152000;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       n_reset, enable, ioctl_download, ioctl_wr;
  logic [7:0] ioctl_data;
  logic [1:0] baud_sel, eol_mode;
  logic       ioctl_wait, txd, busy, overflow;
  logic [4:0] level;

  ioctl_ascii_loader #(.CLK_HZ(CLK_HZ), .DEPTH(DEPTH)) dut (
    .clk(clk), .n_reset(n_reset), .enable(enable),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
    .baud_sel(baud_sel), .eol_mode(eol_mode), .txd(txd),
    .busy(busy), .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int         per_exp[$];
  logic [7:0] rx_q[$];
  int         st_q[$];
  int         rx_ferr = 0;
  bit         mon_clr = 1'b1;

  int         rx_n, rx_per, rx_st;
  logic [10:0] rx_bits;
  bit         rx_act = 1'b0;

  // Serial receiver: samples each bit at its centre on falling clock.
  always @(negedge clk) begin
    if (mon_clr) rx_act = 1'b0;
    else if (!rx_act) begin
      if (txd === 1'b0) begin
        rx_act = 1'b1;
        rx_n = 0;
        rx_st = cyc;
        if (per_exp.size() > 0) rx_per = per_exp.pop_front();
        else begin rx_per = 10; rx_ferr++; end
      end
    end else begin
      rx_n++;
      if (rx_n % rx_per == rx_per / 2) begin
        rx_bits[rx_n / rx_per] = txd;
        if (rx_n / rx_per == 10) begin
          rx_act = 1'b0;
          if (rx_bits[0] !== 1'b0 || rx_bits[10:9] !== 2'b11) rx_ferr++;
          rx_q.push_back(rx_bits[8:1]);
          st_q.push_back(rx_st);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    ioctl_data = b;
    ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0;
  endtask

  // Model: eol rules decide what, if anything, reaches the serial line.
  task automatic mdl_push(input logic [7:0] b, input int per);
    if (eol_mode == 2'd1 && b == 8'h0A) return;
    if (eol_mode == 2'd3 && b == 8'h0D) return;
    exp_q.push_back((eol_mode == 2'd2 && b == 8'h0A) ? 8'h0D : b);
    per_exp.push_back(per);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin step(); n++; end
    step();
    chk(tag, busy, 1'b0);
  endtask

  task automatic wait_fall(input string tag);
    int n = 0;
    while (txd !== 1'b0 && n < 200) begin step(); n++; end
    chk(tag, txd, 1'b0);
  endtask

  task automatic clear_q();
    exp_q.delete(); per_exp.delete();
    rx_q.delete(); st_q.delete();
    rx_ferr = 0;
  endtask

  task automatic cmp_rx(input string tag);
    chk({tag, "_cnt"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({tag, "_byte"}, rx_q[i], exp_q[i]);
    chk({tag, "_ferr"}, rx_ferr, 0);
    clear_q();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] ab, b;
    int n, sent, maxlvl, lvl_prev, mfill;
    bit hi_ok;

    n_reset = 1'b0; enable = 1'b1; ioctl_download = 1'b1;
    ioctl_wr = 1'b0; ioctl_data = 8'h00;
    baud_sel = 2'd3; eol_mode = 2'd0;
    repeat (3) step();
    chk("rst_txd", txd, 1'b1);
    chk("rst_wait", ioctl_wait, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_level", level, 0);
    n_reset = 1'b1;
    repeat (4) step();
    chk("rel_txd", txd, 1'b1);
    mon_clr = 1'b0;

    // Single 0x41 at 9600 baud: 120 clocks per bit here.
    baud_sel = 2'd2;
    ab = 8'h41;
    mdl_push(ab, 120);
    wr_byte(ab);
    chk("a_level", level, 1);
    chk("a_busy", busy, 1'b1);
    wait_fall("a_start");
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      step(); n++;
      if (busy === 1'b1 && n % 120 == 60)
        chk("a_bit", txd, (n / 120 == 0) ? 1'b0 :
                          (n / 120 <= 8) ? ab[n / 120 - 1] : 1'b1);
    end
    chk("a_frame_len", n, 11 * 120);
    cmp_rx("a");

    // CR/LF handling under each eol mode.
    baud_sel = 2'd3;
    for (int m = 0; m < 4; m++) begin
      eol_mode = 2'(m);
      mdl_push(8'h0D, 10);
      mdl_push(8'h0A, 10);
      wr_byte(8'h0D);
      wr_byte(8'h0A);
      wait_idle("eol_idle", 1000);
      if (st_q.size() >= 2) chk("eol_gap", st_q[1] - st_q[0], 110);
      cmp_rx("eol");
    end

    // 20 random bytes, HPS honouring ioctl_wait.
    eol_mode = 2'd0;
    sent = 0; n = 0; maxlvl = 0; lvl_prev = level;
    while (sent < 20 && n < 5000) begin
      if (ioctl_wait === 1'b0) begin
        b = 8'($urandom_range(0, 255));
        ioctl_data = b; ioctl_wr = 1'b1;
        mdl_push(b, 10);
        sent++;
      end
      step();
      ioctl_wr = 1'b0;
      n++;
      chk("w_wait", ioctl_wait, lvl_prev >= DEPTH - 2);
      if (level > maxlvl) maxlvl = level;
      lvl_prev = level;
    end
    chk("w_sent", sent, 20);
    hi_ok = (maxlvl >= DEPTH - 2) && (maxlvl < DEPTH);
    chk("w_maxlvl", hi_ok, 1'b1);
    chk("w_ovf", overflow, 1'b0);
    wait_idle("w_idle", 4000);
    cmp_rx("w");

    // 20 back-to-back writes ignoring ioctl_wait, slow first frame.
    baud_sel = 2'd1;
    mfill = 0;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 255));
      wr_byte(b);
      if (i == 0) mdl_push(b, 960);
      else if (mfill < DEPTH) begin mdl_push(b, 10); mfill++; end
    end
    baud_sel = 2'd3;
    chk("o_level", level, DEPTH);
    chk("o_ovf", overflow, 1'b1);
    chk("o_wait", ioctl_wait, 1'b1);
    ioctl_download = 1'b0;
    wait_idle("o_idle", 13000);
    cmp_rx("o");
    chk("o_ovf_held", overflow, 1'b1);
    wr_byte(8'h55);
    step();
    chk("o_nodl_level", level, 0);
    chk("o_nodl_busy", busy, 1'b0);
    ioctl_download = 1'b1;
    step(); step();
    chk("o_ovf_clr", overflow, 1'b0);

    // enable dropped during data bit 3.
    wr_byte(8'h3C);
    wait_fall("e_start0");
    wr_byte(8'h99);
    repeat (43) step();
    mon_clr = 1'b1;
    enable = 1'b0;
    step();
    chk("e_txd", txd, 1'b1);
    chk("e_level", level, 0);
    chk("e_busy", busy, 1'b0);
    chk("e_wait", ioctl_wait, 1'b0);
    enable = 1'b1;
    clear_q();
    step();
    mon_clr = 1'b0;
    mdl_push(8'hA5, 10);
    wr_byte(8'hA5);
    step();
    chk("e_restart", txd, 1'b0);
    wait_idle("e_idle", 1000);
    cmp_rx("e");

    // Reset pulse during STOP1 with five bytes queued.
    wr_byte(8'h11);
    wait_fall("r_start");
    for (int i = 0; i < 5; i++) wr_byte(8'(8'h20 + i));
    chk("r_level_pre", level, 5);
    repeat (88) step();
    #3;
    mon_clr = 1'b1;
    n_reset = 1'b0;
    #1;
    chk("r_txd", txd, 1'b1);
    chk("r_busy", busy, 1'b0);
    chk("r_level", level, 0);
    chk("r_wait", ioctl_wait, 1'b0);
    chk("r_ovf", overflow, 1'b0);
    step();
    n_reset = 1'b1;
    hi_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (txd !== 1'b1 || busy !== 1'b0) hi_ok = 1'b0;
    end
    chk("r_quiet", hi_ok, 1'b1);
    clear_q();
    mon_clr = 1'b0;
    mdl_push(8'h7E, 10);
    wr_byte(8'h7E);
    wait_idle("r_idle", 1000);
    cmp_rx("r");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ioctl_ascii_loader.md
IOCTL_ASCII_LOADER -- requirements
Module: ioctl_ascii_loader

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 48000000, giving the clk frequency in Hz.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving FIFO entries; the value SHALL be a power of 2 and at least 4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port n_reset, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: loader active (file-load mode selected).
REQ-006 The block SHALL have port ioctl_download, input, 1 bit: HPS download in progress.
REQ-007 The block SHALL have port ioctl_wr, input, 1 bit: one-cycle byte strobe.
REQ-008 The block SHALL have port ioctl_data, input, 8 bits: download byte.
REQ-009 The block SHALL have port ioctl_wait, output, 1 bit: backpressure to HPS.
REQ-010 The block SHALL have port baud_sel, input, 2 bits: 0=300, 1=1200, 2=9600, 3=115200 baud.
REQ-011 The block SHALL have port eol_mode, input, 2 bits: 0=pass, 1=drop 0x0A, 2=map 0x0A to 0x0D, 3=drop 0x0D.
REQ-012 The block SHALL have port txd, output, 1 bit: serial data to the ACIA RX, idle high.
REQ-013 The block SHALL have port busy, output, 1 bit: FIFO non-empty or a frame in progress.
REQ-014 The block SHALL have port overflow, output, 1 bit: sticky flag indicating a byte was lost.
REQ-015 The block SHALL have port level, output, clog2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-016 A byte SHALL be accepted on a cycle with ioctl_wr=1, ioctl_download=1 and enable=1, after eol_mode filtering; a dropped byte SHALL NOT change level.
REQ-017 The FIFO SHALL be first-in first-out, with pointers wrapping modulo DEPTH.
REQ-018 A simultaneous push and pop SHALL leave level unchanged.
REQ-019 ioctl_wait SHALL be registered and SHALL be 1 the cycle after level >= DEPTH-2, so that one in-flight write still fits.
REQ-020 A push while level==DEPTH SHALL be discarded and SHALL set overflow, which stays set until reset or a rising edge of ioctl_download.
REQ-021 The bit period SHALL be floor(CLK_HZ/baud) clocks, with the counter sized for 300 baud.
REQ-022 The transmitter SHALL be a state machine with states IDLE, START, DATA, STOP1 and STOP2, transmitting 8N2 framing LSB first.
REQ-023 From IDLE, when the FIFO is non-empty, the transmitter SHALL pop the byte, latch baud_sel, and enter START in the same cycle; txd SHALL go low on the next clock edge.
REQ-024 START SHALL send one bit of 0; DATA SHALL send 8 bits using a 3-bit index; STOP1 and STOP2 SHALL each send 1; the transmitter SHALL then return to IDLE, or directly to START if data is pending (no gap between frames).
REQ-025 A baud_sel change mid-frame SHALL take effect only at the next frame.
REQ-026 When ioctl_download falls, accepting bytes SHALL stop and the FIFO SHALL drain normally.
REQ-027 busy SHALL fall on the cycle after STOP2 completes with the FIFO empty.
REQ-028 enable=0 SHALL abort on the next edge: FIFO cleared (level=0), state IDLE, txd=1, ioctl_wait=0; overflow SHALL be held.
REQ-029 txd SHALL be a register output, free of glitches.

Reset
REQ-030 While n_reset=0, the outputs SHALL be txd=1, ioctl_wait=0, busy=0, overflow=0 and level=0; the state SHALL be IDLE with the FIFO pointers and counters at 0.
REQ-031 Reset release SHALL be synchronised with a 2-flop synchroniser; operation SHALL start the 2nd clock after deassertion.
REQ-032 Reset mid-frame SHALL return txd high immediately (asynchronously) and SHALL discard all contents.

Verification
REQ-033 Scenario (default parameters): baud_sel=2, one write of 0x41 -> 5000 clocks per bit; txd=0 then 1,0,0,0,0,0,1,0 then 1,1; busy=1 for 55000 clocks.
REQ-034 Scenario: eol_mode=2, stream 0x0D,0x0A -> two frames of 0x0D, back-to-back; eol_mode=1 with the same stream -> one frame only.
REQ-035 Scenario: 20 consecutive writes with the HPS honouring ioctl_wait -> ioctl_wait=1 once level reaches 14; no overflow; all 20 bytes emitted in order.
REQ-036 Scenario: 20 writes ignoring ioctl_wait -> level saturates at 16; overflow=1; the emitted bytes are the first 16 accepted.
REQ-037 Scenario: enable dropped during DATA bit 3 -> txd=1 and level=0 on the next edge, busy=0; a subsequent write restarts with a clean START bit.
REQ-038 Scenario: n_reset pulsed low mid-STOP1 with 5 bytes queued -> txd=1 asynchronously and all outputs at reset values; no frame after release until a new write.
